// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
package disp_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Scan position: 0 is the least significant digit.
    typedef logic [1:0] digit_idx_t;

    // 2-to-4 decode of the scan position into active-low one-hot anodes.
    function automatic logic [3:0] anode_decode(input digit_idx_t idx);
        logic [3:0] an;
        an = 4'b1111;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment pattern; A-F show a dash.
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; anything outside 0-9 is flagged visually as a dash.
    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/digit_scan_decoder.sv
// Time-multiplexed 4-digit seven-segment driver with a double-buffered BCD value.
//
// Load semantics: load is a one-cycle strobe with no back-pressure. Every
// cycle with load=1 captures bcd_in into the pending buffer (last write wins)
// and raises pending. The pending value moves to the displayed buffer only at a
// frame boundary (the scan tick that selects digit 0). A load in the same cycle
// as a boundary is kept as the next pending value; the boundary transfers the
// value that was pending before it.
module digit_scan_decoder
    import disp_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic        pending,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [3:0]  digit,
    output logic        frame_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [15:0]      active_q, active_d;
    logic [15:0]      pend_buf_q, pend_buf_d;
    logic             pending_q, pending_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       digit_q, digit_d;
    logic             frame_tick_q, frame_tick_d;

    logic             tick;
    logic             boundary;
    logic [3:0]       sel_nibble;
    logic [6:0]       sel_seg;
    logic             upper_zero;

    // Prescaler and scan index: the index advances once per PRESCALE cycles.
    always_comb begin
        tick     = (cnt_q == CNT_W'(PRESCALE - 1));
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        boundary = tick && (idx_d == 2'd0);
    end

    // Double buffer: transfer at the boundary first, then accept any new load.
    always_comb begin
        active_d   = active_q;
        pend_buf_d = pend_buf_q;
        pending_d  = pending_q;
        if (boundary && pending_q) begin
            active_d  = pend_buf_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pend_buf_d = bcd_in;
            pending_d  = 1'b1;
        end
    end

    // Digit mux and leading-zero test use the buffer as it will be after this edge,
    // so digit 0 of a new frame already shows the newly transferred value.
    always_comb begin
        sel_nibble = active_d[{idx_d, 2'b00} +: 4];
        upper_zero = 1'b0;
        case (idx_d)
            2'd3:    upper_zero = (active_d[15:12] == 4'd0);
            2'd2:    upper_zero = (active_d[15:8] == 8'd0);
            2'd1:    upper_zero = (active_d[15:4] == 12'd0);
            default: upper_zero = 1'b0;
        endcase
    end

    bcd_to_7seg u_bcd_to_7seg (
        .nibble (sel_nibble),
        .seg    (sel_seg)
    );

    // Display outputs change together, only on a scan tick.
    always_comb begin
        an_d         = an_q;
        seg_d        = seg_q;
        digit_d      = digit_q;
        frame_tick_d = boundary;
        if (tick) begin
            an_d    = anode_decode(idx_d);
            digit_d = sel_nibble;
            seg_d   = (blank_lz && upper_zero) ? SEG_BLANK : sel_seg;
        end
    end

    // State registers with synchronous reset; reset also drops any pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd3;
            active_q     <= '0;
            pend_buf_q   <= '0;
            pending_q    <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
            digit_q      <= 4'd0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pend_buf_q   <= pend_buf_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            digit_q      <= digit_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pending    = pending_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign digit      = digit_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_digit_scan_decoder.sv
// Bench for digit_scan_decoder: directed scenarios followed by random loads,
// compared every cycle against a time-based reference model.
module tb_digit_scan_decoder;

    localparam int P = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  digit;
    logic        frame_tick;

    always #5 clk = ~clk;

    digit_scan_decoder #(.PRESCALE(P), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .pending    (pending),
        .an         (an),
        .seg        (seg),
        .digit      (digit),
        .frame_tick (frame_tick)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Everything is derived from the number of clock edges since reset release:
    // edge n is a scan tick when n is a multiple of P, and the slot selected by
    // that tick is (n/P - 1) mod 4. Slot 0 starts a frame.
    logic [6:0]  seg_tbl [16];
    int          m_n;
    logic [15:0] m_act, m_pbuf;
    logic        m_pnd;
    logic [3:0]  e_an, e_dig;
    logic [6:0]  e_seg;
    logic        e_ft;

    function automatic bit is_boundary(input int e);
        return (e > 0) && (e % P == 0) && (((e / P) - 1) % 4 == 0);
    endfunction

    task automatic model_edge(input logic r, input logic l, input logic [15:0] b, input logic z);
        int slot;
        logic [3:0] nib;
        if (r) begin
            m_n = 0; m_act = 0; m_pbuf = 0; m_pnd = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dig = 0; e_ft = 0;
            return;
        end
        m_n++;
        e_ft = 0;
        if (m_n % P == 0) begin
            slot = ((m_n / P) - 1) % 4;
            if (slot == 0) begin
                e_ft = 1;
                if (m_pnd) begin
                    m_act = m_pbuf;
                    m_pnd = 0;
                end
            end
            e_an  = ~(4'b0001 << slot);
            nib   = 4'((m_act >> (4 * slot)) & 16'hF);
            e_dig = nib;
            if (slot > 0 && z && (m_act >> (4 * slot)) == 16'd0)
                e_seg = 7'h7F;
            else
                e_seg = seg_tbl[nib];
        end
        if (l) begin
            m_pbuf = b;
            m_pnd  = 1;
        end
    endtask

    task automatic check_all();
        chk("an", {12'd0, an}, {12'd0, e_an});
        chk("seg", {9'd0, seg}, {9'd0, e_seg});
        chk("digit", {12'd0, digit}, {12'd0, e_dig});
        chk("pending", {15'd0, pending}, {15'd0, m_pnd});
        chk("frame_tick", {15'd0, frame_tick}, {15'd0, e_ft});
    endtask

    // ---------------- driver tasks ----------------
    // Called from the falling edge: drive, take one rising edge, check at next fall.
    task automatic cycle(input logic r, input logic l, input logic [15:0] b, input logic z);
        rst = r; load = l; bcd_in = b; blank_lz = z;
        @(posedge clk);
        model_edge(r, l, b, z);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input logic z);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, z);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) == 0)      v[4*i +: 4] = 4'd0;
            else if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else                                v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 2) == 0) v = v & (16'hFFFF >> (4 * $urandom_range(1, 3)));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001;
        seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b0110000;
        seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000;
        seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b0111111;

        rst = 1'b1; load = 1'b0; bcd_in = '0; blank_lz = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);

        // Reset release, then load 1234 one cycle later.
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(40, 1'b0);

        // Leading-zero blanking on and off.
        cycle(1'b0, 1'b1, 16'h0007, 1'b1);
        idle(40, 1'b1);
        idle(32, 1'b0);

        // Inner zero below a nonzero digit stays visible.
        cycle(1'b0, 1'b1, 16'h0105, 1'b1);
        idle(40, 1'b1);

        // Last load wins; a load on the boundary edge becomes the next pending value.
        cycle(1'b0, 1'b1, 16'h1111, 1'b0);
        idle(5, 1'b0);
        cycle(1'b0, 1'b1, 16'h2222, 1'b0);
        while (!is_boundary(m_n + 1)) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h3333, 1'b0);
        idle(40, 1'b0);

        // Invalid nibbles show a dash with the raw nibble on digit.
        cycle(1'b0, 1'b1, 16'hA9F0, 1'b0);
        idle(40, 1'b0);

        // Reset mid-frame with a load pending.
        cycle(1'b0, 1'b1, 16'h5555, 1'b0);
        idle(3, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        idle(36, 1'b0);

        // Random traffic, including occasional reset and boundary-coincident loads.
        begin
            logic z;
            z = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 49) == 0) z = ~z;
                cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, rand_bcd(), z);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
